// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and framing constants for the UART link.
//               Used by the receiver and shared with the transmitter.
//               Contents:
//                 uart_rx_state_e : receiver FSM state encoding
//                 START_BITS      : start bits per frame
//                 STOP_BITS       : stop bits per frame sent by the transmitter
//                 clog2_min1()    : ceil(log2(n)), never less than 1
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_e;

  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 4;

  // Width of an index register that must exist even for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchronizer with a configurable reset value.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset (flops load RESET_VAL)
//               i_d  - asynchronous input
//               o_q  - synchronized output (two clocks of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      o_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. Recovers frames of 1 start bit, BITS_PER_WORD
//               data bits (LSB first) and stop bits from a single serial
//               line, assembles W_OUT/BITS_PER_WORD consecutive frames into
//               one packet (word 0 = first frame) and presents it on a
//               valid/ready master stream.
// Parameters  : CLOCKS_PER_PULSE - clocks per bit period (>= 2)
//               W_OUT            - packet width (multiple of BITS_PER_WORD)
//               BITS_PER_WORD    - data bits per frame
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               rx        - asynchronous serial input, idles high
//               m_data    - assembled packet, [word][bit]
//               m_valid   - m_data holds an unconsumed packet
//               m_ready   - downstream accepts the packet
//               frame_err - 1-cycle pulse: first stop bit sampled low
//               overflow  - 1-cycle pulse: completed packet dropped
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int W_OUT            = 16,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               rx,
  output logic [W_OUT/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0] m_data,
  output logic                                               m_valid,
  input  logic                                               m_ready,
  output logic                                               frame_err,
  output logic                                               overflow
);

  localparam int c_NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int c_CNT_W     = $clog2(CLOCKS_PER_PULSE);
  localparam int c_BIT_W     = $clog2(BITS_PER_WORD + 1);
  localparam int c_IDX_W     = clog2_min1(c_NUM_WORDS);

  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(BITS_PER_WORD - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(c_NUM_WORDS - 1);

  // --------------------------------------------------------------------------
  // Input synchronizer and edge history. Both reset high so that a line that
  // is idle across reset never looks like a start edge.
  // --------------------------------------------------------------------------
  logic w_rx_s;
  logic r_rx_prev;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_prev <= w_rx_s;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM: state and bit-timing counters
  // --------------------------------------------------------------------------
  uart_rx_state_e     r_state;
  uart_rx_state_e     w_state_nxt;
  logic [c_CNT_W-1:0] r_clk_cnt;
  logic [c_CNT_W-1:0] w_clk_cnt_nxt;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic [c_BIT_W-1:0] w_bit_cnt_nxt;
  logic               w_shift_en;
  logic               w_stop_ok;
  logic               w_stop_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_en    = 1'b0;
    w_stop_ok     = 1'b0;
    w_stop_bad    = 1'b0;

    case (r_state)
      IDLE: begin
        // Counter held at 0 so START begins counting from the edge.
        w_clk_cnt_nxt = '0;
        if (r_rx_prev && !w_rx_s) begin
          w_state_nxt = START;
        end
      end

      START: begin
        // Half a bit in: a line back high means a glitch, not a start bit.
        if (r_clk_cnt == c_HALF_LAST) begin
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = w_rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        // From mid-start, each full period lands on the middle of a data bit.
        if (r_clk_cnt == c_FULL_LAST) begin
          w_clk_cnt_nxt = '0;
          w_shift_en    = 1'b1;
          w_bit_cnt_nxt = r_bit_cnt + c_BIT_W'(1);
          if (r_bit_cnt == c_BIT_LAST) begin
            w_state_nxt = STOP;
          end
        end
      end

      STOP: begin
        // Only the first stop bit is checked; the rest pass while in IDLE.
        if (r_clk_cnt == c_FULL_LAST) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = IDLE;
          if (w_rx_s) begin
            w_stop_ok = 1'b1;
          end else begin
            w_stop_bad = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Word shift register, packet assembly and output stream
  // --------------------------------------------------------------------------
  logic [BITS_PER_WORD-1:0]                  r_shift;
  logic [c_NUM_WORDS-1:0][BITS_PER_WORD-1:0] r_asm;
  logic [c_NUM_WORDS-1:0][BITS_PER_WORD-1:0] w_packet;
  logic [c_IDX_W-1:0]                        r_word_idx;
  logic                                      w_pkt_done;
  logic                                      w_load;

  // The final word is still in the shift register on the completing cycle,
  // so the packet is the assembly buffer with the current slot overlaid.
  always_comb begin
    w_packet             = r_asm;
    w_packet[r_word_idx] = r_shift;
  end

  assign w_pkt_done = w_stop_ok && (r_word_idx == c_IDX_LAST);
  // A packet may load when the output is free or is being consumed now.
  assign w_load     = w_pkt_done && (!m_valid || m_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_asm      <= '0;
      r_word_idx <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err <= w_stop_bad;
      overflow  <= w_pkt_done && !w_load;

      // Bits arrive LSB first: enter at the MSB and move down.
      if (w_shift_en) begin
        r_shift <= {w_rx_s, r_shift[BITS_PER_WORD-1:1]};
      end

      if (w_stop_ok) begin
        r_asm[r_word_idx] <= r_shift;
        r_word_idx        <= (r_word_idx == c_IDX_LAST) ? '0 : r_word_idx + c_IDX_W'(1);
      end else if (w_stop_bad) begin
        r_word_idx <= '0;
      end

      // A new load takes priority over the handshake clearing m_valid.
      if (w_load) begin
        m_data  <= w_packet;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Stimulus pushes expected
//               packets into a queue; a monitor pops and compares on every
//               accepted handshake and checks that a stalled packet is held.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPP   = 4;
  localparam int W_OUT = 16;
  localparam int BPW   = 8;
  localparam int NW    = W_OUT / BPW;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    rx;
  logic [NW-1:0][BPW-1:0]  m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    frame_err;
  logic                    overflow;

  always #5 clk = ~clk;

  uart_rx #(
    .CLOCKS_PER_PULSE (CPP),
    .W_OUT            (W_OUT),
    .BITS_PER_WORD    (BPW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int               checks    = 0;
  int               errors    = 0;
  logic [W_OUT-1:0] exp_q[$];
  int               fe_total  = 0;
  int               ovf_total = 0;
  int               mv_total  = 0;
  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic [W_OUT-1:0] prev_data  = '0;

  // Monitor: scoreboard pop on handshake, hold check while stalled.
  always @(negedge clk) begin
    logic [W_OUT-1:0] exp_v;
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (frame_err) fe_total++;
      if (overflow)  ovf_total++;
      if (m_valid)   mv_total++;
      if (prev_valid && !prev_ready) begin
        checks++;
        if (!m_valid || m_data !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: got m_valid=%0b m_data=%h, required m_valid=1 m_data=%h",
                   m_valid, m_data, prev_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_packet: got m_data=%h, required no packet", m_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (m_data !== exp_v) begin
            errors++;
            $display("FAIL packet_data: got %h, required %h", m_data, exp_v);
          end
        end
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPP);
  endtask

  task automatic send_frame(input logic [BPW-1:0] d, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < BPW; i++) send_bit(d[i]);
    send_bit(stop_ok);
    for (int i = 1; i < STOP_BITS; i++) send_bit(1'b1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending packets, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ovf0, mv0;

    rst     = 1'b1;
    rx      = 1'b1;
    m_ready = 1'b1;
    tick(4);
    rst = 1'b0;
    @(negedge clk);
    check("reset_m_valid",   32'(m_valid),   32'h0);
    check("reset_m_data",    32'(m_data),    32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overflow",  32'(overflow),  32'h0);
    tick(2);

    // 1: basic two-word packet
    fe0 = fe_total; ovf0 = ovf_total; mv0 = mv_total;
    exp_q.push_back(16'h3CA5);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    drain("t1");
    tick(8);
    check("t1_valid_cycles", 32'(mv_total - mv0),   32'd1);
    check("t1_frame_err",    32'(fe_total - fe0),   32'd0);
    check("t1_overflow",     32'(ovf_total - ovf0), 32'd0);

    // 2: back-pressure, second packet dropped
    fe0 = fe_total; ovf0 = ovf_total;
    m_ready = 1'b0;
    exp_q.push_back(16'h2211);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    tick(8);
    check("t2_overflow",   32'(ovf_total - ovf0), 32'd1);
    check("t2_held_data",  32'(m_data),           32'h2211);
    m_ready = 1'b1;
    drain("t2");
    tick(4);
    check("t2_valid_after", 32'(m_valid),         32'h0);
    check("t2_frame_err",   32'(fe_total - fe0),  32'd0);

    // 3: one-clock glitch is a false start
    fe0 = fe_total; mv0 = mv_total;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(16 * CPP);
    check("t3_valid_cycles", 32'(mv_total - mv0), 32'd0);
    check("t3_frame_err",    32'(fe_total - fe0), 32'd0);

    // 4: framing error discards partial packet
    fe0 = fe_total; ovf0 = ovf_total;
    send_frame(8'h5A, 1'b0);
    exp_q.push_back(16'h0201);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    drain("t4");
    tick(4);
    check("t4_frame_err", 32'(fe_total - fe0),   32'd1);
    check("t4_overflow",  32'(ovf_total - ovf0), 32'd0);

    // 5: reset in the middle of word 1
    send_frame(8'h77, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("t5_reset_m_valid", 32'(m_valid), 32'h0);
    check("t5_reset_m_data",  32'(m_data),  32'h0);
    tick(2);
    fe0 = fe_total;
    exp_q.push_back(16'h00FF);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    drain("t5");
    check("t5_frame_err", 32'(fe_total - fe0), 32'd0);

    // 6: back-to-back frames, two packets
    ovf0 = ovf_total; mv0 = mv_total;
    exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'hCAFE);
    send_frame(8'hEF, 1'b1);
    send_frame(8'hBE, 1'b1);
    send_frame(8'hFE, 1'b1);
    send_frame(8'hCA, 1'b1);
    drain("t6");
    tick(8);
    check("t6_valid_cycles", 32'(mv_total - mv0),   32'd2);
    check("t6_overflow",     32'(ovf_total - ovf0), 32'd0);

    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
